// File: rtl/pr_bank.sv
// P-R register bank: register file with ZMVCLEGYX flags in R0, NB/Q/BS system registers
// and a context save/load sequencer. Define PR_PARITY_EN to add per-register odd parity.
module pr_bank #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8,
   parameter int AW     = 3,
   parameter int NB_W   = 4
) (
   input  logic              clk_sys,
   input  logic              clm_,
   input  logic [DATA_W-1:0] w,
   input  logic [AW-1:0]     w_addr,
   input  logic              w_we,
   input  logic [AW-1:0]     rd_addr,
   input  logic [1:0]        l_mode,
   output logic [DATA_W-1:0] l,
   input  logic [8:0]        flag_we,
   input  logic [8:0]        flag_d,
   output logic [8:0]        r0,
   input  logic              nb_we,
   output logic [NB_W-1:0]   nb,
   output logic              q,
   output logic              bs,
`ifdef PR_PARITY_EN
   input  logic              par_inj,
   output logic              par_err,
`endif
   input  logic              ctx_save,
   input  logic              ctx_load,
   output logic              ctx_busy,
   output logic              ctx_done,
   output logic [DATA_W-1:0] ctx_dout,
   output logic              ctx_valid,
   input  logic              ctx_ready,
   input  logic [DATA_W-1:0] ctx_din,
   input  logic              ctx_din_valid,
   output logic              ctx_din_ready
);

   typedef enum logic [1:0] {S_IDLE, S_SAVE, S_LOAD} state_t;

   state_t            r_state, w_state_nx;
   logic [AW-1:0]     r_idx, w_idx_nx;
   logic              r_done, w_done_nx;
   logic [DATA_W-1:0] r_regs [NREGS];
   logic [NB_W-1:0]   r_nb;
   logic              r_q, r_bs;

   logic              w_idle, w_last;
   logic              w_wr_en;
   logic [AW-1:0]     w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic              w_r0_we;
   logic [DATA_W-1:0] w_r0_nx;

   assign w_idle = (r_state == S_IDLE);
   assign w_last = (r_idx == AW'(NREGS - 1));

   always_ff @(posedge clk_sys or negedge clm_) begin
      if (!clm_) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_idx_nx      = r_idx;
      w_done_nx     = 1'b0;
      ctx_busy      = 1'b0;
      ctx_valid     = 1'b0;
      ctx_din_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            // save wins over a simultaneous load; the load request is dropped
            if (ctx_save) begin
               w_state_nx = S_SAVE;
               w_idx_nx   = '0;
            end else if (ctx_load) begin
               w_state_nx = S_LOAD;
               w_idx_nx   = '0;
            end
         end
         S_SAVE: begin
            ctx_busy  = 1'b1;
            ctx_valid = 1'b1;
            if (ctx_ready) begin
               if (w_last) begin
                  w_state_nx = S_IDLE;
                  w_idx_nx   = '0;
                  w_done_nx  = 1'b1;
               end else begin
                  w_idx_nx = r_idx + 1'b1;
               end
            end
         end
         S_LOAD: begin
            ctx_busy      = 1'b1;
            ctx_din_ready = 1'b1;
            if (ctx_din_valid) begin
               if (w_last) begin
                  w_state_nx = S_IDLE;
                  w_idx_nx   = '0;
                  w_done_nx  = 1'b1;
               end else begin
                  w_idx_nx = r_idx + 1'b1;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // A single write port shared by bus W (idle only) and the context loader
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = w_addr;
      w_wr_data = w;
      if (r_state == S_LOAD) begin
         w_wr_en   = ctx_din_valid;
         w_wr_addr = r_idx;
         w_wr_data = ctx_din;
      end else if (w_idle) begin
         w_wr_en = w_we;
      end
   end

   // Flags sit in the top nine bits of R0; flag_we bits override bus W per bit
   always_comb begin
      w_r0_nx = (w_wr_en && (w_wr_addr == '0)) ? w_wr_data : r_regs[0];
      w_r0_we = (w_wr_en && (w_wr_addr == '0)) || (w_idle && (|flag_we));
      if (w_idle) begin
         for (int unsigned j = 0; j < 9; j++) begin
            if (flag_we[j]) w_r0_nx[DATA_W-9+j] = flag_d[j];
         end
      end
   end

   always_ff @(posedge clk_sys or negedge clm_) begin
      if (!clm_) begin
         for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         if (w_r0_we) r_regs[0] <= w_r0_nx;
         for (int unsigned i = 1; i < NREGS; i++) begin
            if (w_wr_en && (w_wr_addr == AW'(i))) r_regs[i] <= w_wr_data;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge clm_) begin
      if (!clm_) begin
         r_nb <= '0;
         r_q  <= 1'b0;
         r_bs <= 1'b0;
      end else if (w_idle && nb_we) begin
         r_nb <= w[NB_W-1:0];
         r_q  <= w[5];
         r_bs <= w[4];
      end
   end

`ifdef PR_PARITY_EN
   logic r_par [NREGS];

   always_ff @(posedge clk_sys or negedge clm_) begin
      if (!clm_) begin
         for (int unsigned i = 0; i < NREGS; i++) r_par[i] <= 1'b1;
      end else begin
         if (w_r0_we) r_par[0] <= ~(^w_r0_nx) ^ par_inj;
         for (int unsigned i = 1; i < NREGS; i++) begin
            if (w_wr_en && (w_wr_addr == AW'(i))) r_par[i] <= ~(^w_wr_data) ^ par_inj;
         end
      end
   end

   assign par_err = ((l_mode == 2'd0) && !(^{r_regs[rd_addr], r_par[rd_addr]})) ||
                    ((r_state == S_SAVE) && !(^{r_regs[r_idx], r_par[r_idx]}));
`endif

   always_comb begin
      case (l_mode)
         2'd0:    l = r_regs[rd_addr];
         2'd1:    l = DATA_W'(r_regs[0][DATA_W-1 -: 8]);
         default: l = '1;
      endcase
   end

   assign r0       = r_regs[0][DATA_W-1 -: 9];
   assign nb       = r_nb;
   assign q        = r_q;
   assign bs       = r_bs;
   assign ctx_done = r_done;
   assign ctx_dout = r_regs[r_idx];

endmodule
